mem_stage: RTL

- Memory-access pipeline stage directly downstream of execute.
- Consumes the execute result (address or ALU value) and the forwarded second register operand (store data).
- Performs loads/stores over a single-outstanding req/ack data bus; otherwise passes the ALU value through.
- Produces a registered writeback value and back-pressures upstream with a stall while a bus access is in flight.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_load_align.sv | 34 +++
 rtl/mem_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory-access stage.
//   - mem_size_e  : access size encoding carried on mem_size
//   - mem_state_e : stage FSM states
//   - byte_en()   : byte-lane enables for a size/offset pair
//   - misaligned(): illegal size or unaligned offset for that size
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_e;

    function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input mem_size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: right-aligns the addressed lane of a bus word and extends it.
// Ports:
//   rdata       in  raw bus read word
//   addr        in  byte offset within the word
//   size        in  access size (mem_size_e encoding)
//   is_unsigned in  1 = zero-extend, 0 = sign-extend
//   data        out aligned, extended value (0 for the illegal size)
module load_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (mem_size_e'(size))
            SZ_BYTE: data = is_unsigned ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                        : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = is_unsigned ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                        : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            SZ_WORD: data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage after execute. Performs loads and
// stores over a single-outstanding req/ack bus, passes ALU values through
// otherwise, and produces a registered writeback pulse.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   in_valid, exe_out,
//   store_data, mem_rd, mem_wr,
//   mem_size, mem_unsigned     instruction from execute
//   stall                      combinational back-pressure to upstream
//   bus_req/we/addr/be/wdata   registered bus request fields
//   bus_ack, bus_rdata         bus completion pulse and read data
//   out_valid, wb_data,
//   misalign, bus_err          registered writeback result and flags
// Build option: define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYC
// REQ cycles without bus_ack (bus_err reported); otherwise REQ waits forever.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] exe_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign,
    output logic              bus_err
);

    mem_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [DATA_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;

    logic              mem_op;
    logic              illegal;
    logic              timeout_hit;
    logic [DATA_W-1:0] ld_data;
    mem_size_e         in_size;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_err_q, bus_err_d;

    assign timeout_hit = (state_q == REQ) && !bus_ack
                      && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign bus_err     = bus_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
    assign bus_err            = 1'b0;
`endif

    assign in_size = mem_size_e'(mem_size);
    assign mem_op  = in_valid & (mem_rd | mem_wr);
    assign illegal = (mem_rd & mem_wr) | misaligned(in_size, exe_out[1:0]);

    // Stall also drops in the timeout cycle so upstream retires the aborted
    // op on the same edge instead of re-presenting it to IDLE.
    assign stall = ((state_q == IDLE) & mem_op & ~illegal)
                 | ((state_q == REQ) & ~bus_ack & ~timeout_hit);

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata       (bus_rdata),
        .addr        (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wb_data_d   = wb_data_q;
        out_valid_d = 1'b0;
        misalign_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        bus_err_d   = 1'b0;
        wait_cnt_d  = '0;
        if ((state_q == REQ) && !bus_ack)
            wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (illegal) begin
                        out_valid_d = 1'b1;
                        misalign_d  = 1'b1;
                        wb_data_d   = '0;
                    end else begin
                        state_d    = REQ;
                        bus_req_d  = 1'b1;
                        bus_we_d   = mem_wr;
                        bus_addr_d = {exe_out[DATA_W-1:2], 2'b00};
                        bus_be_d   = byte_en(in_size, exe_out[1:0]);
                        case (in_size)
                            SZ_BYTE: bus_wdata_d = {(DATA_W/8){store_data[7:0]}};
                            SZ_HALF: bus_wdata_d = {(DATA_W/16){store_data[15:0]}};
                            default: bus_wdata_d = store_data;
                        endcase
                        off_d  = exe_out[1:0];
                        size_d = mem_size;
                        uns_d  = mem_unsigned;
                    end
                end else if (in_valid) begin
                    out_valid_d = 1'b1;
                    wb_data_d   = exe_out;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    wb_data_d   = bus_we_q ? '0 : ld_data;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    wb_data_d   = '0;
`ifdef MEM_TIMEOUT_EN
                    bus_err_d   = 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wb_data_q   <= '0;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wb_data_q   <= wb_data_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
`ifdef MEM_TIMEOUT_EN
            bus_err_q   <= bus_err_d;
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign out_valid = out_valid_q;
    assign wb_data   = wb_data_q;
    assign misalign  = misalign_q;

endmodule
